// File: rtl/conv_requant_shift_pkg.sv
// Shared constants and types for the conv output requantization stage.
// Lane k of a beat carries channel j, picture i with k = j*PICTURE_NUM + i.
`ifndef PICTURE_NUM
`define PICTURE_NUM 2
`endif
`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif
`define LANE_IDX(j, i) ((j) * `PICTURE_NUM + (i))

package conv_requant_shift_pkg;

  localparam int PICTURE_NUM   = `PICTURE_NUM;
  localparam int WIDTH_DATA    = `WIDTH_DATA;
  localparam int ACC_WIDTH_DEF = 32;
  localparam int OUT_WIDTH     = 2 * `WIDTH_DATA;
  localparam int OUT_MAX       = 32767;
  localparam int OUT_MIN       = -32768;

  typedef enum logic [1:0] {
    PARA_EMPTY = 2'd0,
    PARA_ARMED = 2'd1,
    PARA_BUSY  = 2'd2
  } para_state_e;

endpackage

// File: rtl/conv_requant_shift_requant_lane.sv
// One lane of the requant pipeline: bias add, two-stage multiply,
// rounding arithmetic shift and 16-bit saturation (five register stages).
module conv_requant_shift_requant_lane
  import conv_requant_shift_pkg::*;
#(
  parameter int ACC_WIDTH   = 32,
  parameter int SCALE_WIDTH = 32,
  parameter int SHIFT_WIDTH = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4:0]                    stage_en,
  input  logic signed [ACC_WIDTH-1:0]   acc,
  input  logic signed [ACC_WIDTH-1:0]   bias,
  input  logic signed [SCALE_WIDTH-1:0] scale,
  input  logic [SHIFT_WIDTH-1:0]        shift,
  output logic signed [OUT_WIDTH-1:0]   result
);

  localparam int PW    = ACC_WIDTH + SCALE_WIDTH;
  localparam int RW    = PW + 1;
  localparam int LO_W  = SCALE_WIDTH / 2;
  localparam int HI_W  = SCALE_WIDTH - LO_W;
  localparam int LO_PW = ACC_WIDTH + LO_W + 1;
  localparam int HI_PW = ACC_WIDTH + HI_W;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0]   s1_q;
  logic signed [SCALE_WIDTH-1:0] scale1_q;
  logic [SHIFT_WIDTH-1:0]        shift1_q, shift2_q, shift3_q;
  logic signed [LO_PW-1:0]       lo_q;
  logic signed [HI_PW-1:0]       hi_q;
  logic signed [PW-1:0]          p_q;
  logic signed [RW-1:0]          r_q;

  logic signed [ACC_WIDTH:0]     sum_w;
  logic signed [ACC_WIDTH-1:0]   sum_sat;
  logic signed [LO_PW-1:0]       lo_prod;
  logic signed [HI_PW-1:0]       hi_prod;
  logic signed [PW-1:0]          p_next;
  logic signed [RW-1:0]          rnd, rsum, r_next;

  // The scale is split into an unsigned low half and a signed high half so
  // each multiply stage is narrower; the halves recombine exactly in S3.
  always_comb begin
    sum_w = {acc[ACC_WIDTH-1], acc} + {bias[ACC_WIDTH-1], bias};
    if (sum_w[ACC_WIDTH] != sum_w[ACC_WIDTH-1]) sum_sat = sum_w[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    else sum_sat = sum_w[ACC_WIDTH-1:0];
    lo_prod = LO_PW'(s1_q) * LO_PW'($signed({1'b0, scale1_q[LO_W-1:0]}));
    hi_prod = HI_PW'(s1_q) * HI_PW'($signed(scale1_q[SCALE_WIDTH-1:LO_W]));
    p_next  = (PW'(hi_q) <<< LO_W) + PW'(lo_q);
    rnd     = (shift3_q != '0) ? (RW'(1) <<< (shift3_q - 1'b1)) : '0;
    rsum    = RW'(p_q) + rnd;
    r_next  = rsum >>> shift3_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      scale1_q <= '0;
      shift1_q <= '0;
      shift2_q <= '0;
      shift3_q <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      p_q      <= '0;
      r_q      <= '0;
      result   <= '0;
    end else begin
      if (stage_en[0]) begin
        s1_q     <= sum_sat;
        scale1_q <= scale;
        shift1_q <= shift;
      end
      if (stage_en[1]) begin
        lo_q     <= lo_prod;
        hi_q     <= hi_prod;
        shift2_q <= shift1_q;
      end
      if (stage_en[2]) begin
        p_q      <= p_next;
        shift3_q <= shift2_q;
      end
      if (stage_en[3]) r_q <= r_next;
      if (stage_en[4]) begin
        if (r_q > RW'(OUT_MAX))      result <= OUT_WIDTH'(OUT_MAX);
        else if (r_q < RW'(OUT_MIN)) result <= OUT_WIDTH'(OUT_MIN);
        else                         result <= r_q[OUT_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/conv_requant_shift.sv
// Requantization stage: per-channel parameter file with EMPTY/ARMED/BUSY
// load control, a 5-deep valid shift register and one pipeline per lane.
module conv_requant_shift
  import conv_requant_shift_pkg::*;
#(
  parameter int CHANNEL_OUT_NUM = 8,
  parameter int ACC_WIDTH       = ACC_WIDTH_DEF,
  parameter int SCALE_WIDTH     = 32,
  parameter int SHIFT_WIDTH     = 6,
  localparam int LANES          = PICTURE_NUM * CHANNEL_OUT_NUM,
  localparam int ADDR_W         = (CHANNEL_OUT_NUM > 1) ? $clog2(CHANNEL_OUT_NUM) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           para_clear,
  input  logic                           para_wr_en,
  input  logic [ADDR_W-1:0]              para_wr_addr,
  input  logic [ACC_WIDTH-1:0]           para_bias,
  input  logic [SCALE_WIDTH-1:0]         para_scale,
  input  logic [SHIFT_WIDTH-1:0]         para_shift,
  output logic                           para_ready,
  input  logic                           acc_valid,
  input  logic [LANES*ACC_WIDTH-1:0]     acc_data,
  output logic                           shift_valid,
  output logic [LANES*OUT_WIDTH-1:0]     shift_data_out,
  output logic                           err_sticky,
  output para_state_e                    para_state
);

  // Handshake: a beat is taken on any cycle with acc_valid=1 and
  // para_ready=1; there is no backpressure and results emerge 5 cycles later.

  logic [ACC_WIDTH-1:0]       bias_q  [CHANNEL_OUT_NUM];
  logic [SCALE_WIDTH-1:0]     scale_q [CHANNEL_OUT_NUM];
  logic [SHIFT_WIDTH-1:0]     shift_q [CHANNEL_OUT_NUM];
  logic [CHANNEL_OUT_NUM-1:0] bitmap, bitmap_next;
  para_state_e                state, state_next;
  logic                       err_next, wr_do, addr_bad, accept;
  logic [4:0]                 vld_q;
  logic [OUT_WIDTH-1:0]       lane_out [LANES];

  assign para_ready  = (state != PARA_EMPTY);
  assign para_state  = state;
  assign accept      = acc_valid && para_ready;
  assign shift_valid = vld_q[4];
  assign addr_bad    = int'(para_wr_addr) >= CHANNEL_OUT_NUM;

  always_comb begin
    state_next  = state;
    bitmap_next = bitmap;
    err_next    = err_sticky;
    wr_do       = 1'b0;
    if (para_clear) begin
      state_next  = PARA_EMPTY;
      bitmap_next = '0;
      err_next    = 1'b0;
    end else begin
      if (acc_valid && !para_ready) err_next = 1'b1;
      if (para_wr_en) begin
        if (addr_bad || state != PARA_EMPTY) begin
          err_next = 1'b1;
        end else begin
          wr_do                     = 1'b1;
          bitmap_next[para_wr_addr] = 1'b1;
        end
      end
      unique case (state)
        PARA_EMPTY: if (&bitmap_next) state_next = PARA_ARMED;
        PARA_ARMED: if (acc_valid) state_next = PARA_BUSY;
        PARA_BUSY:  if (!acc_valid && vld_q == '0) state_next = PARA_ARMED;
        default:    state_next = PARA_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PARA_EMPTY;
      bitmap     <= '0;
      err_sticky <= 1'b0;
      vld_q      <= '0;
      for (int c = 0; c < CHANNEL_OUT_NUM; c++) begin
        bias_q[c]  <= '0;
        scale_q[c] <= '0;
        shift_q[c] <= '0;
      end
    end else begin
      state      <= state_next;
      bitmap     <= bitmap_next;
      err_sticky <= err_next;
      vld_q      <= {vld_q[3:0], accept};
      if (wr_do) begin
        bias_q[para_wr_addr]  <= para_bias;
        scale_q[para_wr_addr] <= para_scale;
        shift_q[para_wr_addr] <= para_shift;
      end
    end
  end

  for (genvar j = 0; j < CHANNEL_OUT_NUM; j++) begin : g_ch
    for (genvar i = 0; i < PICTURE_NUM; i++) begin : g_pic
      localparam int K = `LANE_IDX(j, i);
      conv_requant_shift_requant_lane #(
        .ACC_WIDTH  (ACC_WIDTH),
        .SCALE_WIDTH(SCALE_WIDTH),
        .SHIFT_WIDTH(SHIFT_WIDTH)
      ) u_lane (
        .clk     (clk),
        .rst     (rst),
        .stage_en({vld_q[3:0], accept}),
        .acc     (acc_data[K*ACC_WIDTH +: ACC_WIDTH]),
        .bias    (bias_q[j]),
        .scale   (scale_q[j]),
        .shift   (shift_q[j]),
        .result  (lane_out[K])
      );
    end
  end

  always_comb begin
    shift_data_out = '0;
    for (int k = 0; k < LANES; k++) shift_data_out[k*OUT_WIDTH +: OUT_WIDTH] = lane_out[k];
  end

endmodule

// File: doc/conv_requant_shift.md
Name: conv_requant_shift

Overview:
Requantization stage directly upstream of the zero-point/ReLU stage in the conv output path.
- Takes the raw signed convolution accumulators for all lanes.
- Adds a per-output-channel bias, multiplies by a per-channel scale, then applies a rounding arithmetic right shift.
- Saturates each result to signed 16 bits.
- Output bus packing and the valid strobe match the zero-point stage's shift_data_in / M_Valid_Temp inputs exactly, so the two blocks connect with no glue logic.

Parameters:
CHANNEL_OUT_NUM, 8, output channels per beat
ACC_WIDTH, 32, signed accumulator and bias width
SCALE_WIDTH, 32, signed scale multiplier width
SHIFT_WIDTH, 6, right-shift amount width (0..63)
(lane count LANES = `PICTURE_NUM*CHANNEL_OUT_NUM; output lane width 2*`WIDTH_DATA = 16)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
para_clear  in  1  invalidate all channel parameters
para_wr_en  in  1  write one channel's parameters
para_wr_addr  in  clog2(CHANNEL_OUT_NUM)  channel index
para_bias  in  ACC_WIDTH  signed bias
para_scale  in  SCALE_WIDTH  signed scale
para_shift  in  SHIFT_WIDTH  unsigned shift
para_ready  out  1  all channels loaded since the last clear/reset
acc_valid  in  1  accumulator beat valid
acc_data  in  LANES*ACC_WIDTH  lane k = j*`PICTURE_NUM+i at bits [(k+1)*ACC_WIDTH-1 : k*ACC_WIDTH]
shift_valid  out  1  result beat valid (drives M_Valid_Temp)
shift_data_out  out  LANES*16  signed 16-bit results, same lane packing
err_sticky  out  1  protocol error flag, cleared only by rst or para_clear

Behaviour:
- Reset: all of the following are zeroed:
  - parameter register file and loaded-bitmap
  - para_ready, shift_valid, shift_data_out, err_sticky
  - every pipeline valid bit
- Parameter control, with states EMPTY / ARMED / BUSY:
  - EMPTY: para_ready=0. Each para_wr_en writes the entry at para_wr_addr and sets its bitmap bit.
  - EMPTY -> ARMED: when the bitmap becomes all ones; para_ready rises the cycle after the final write.
  - ARMED -> BUSY: on acc_valid=1.
  - BUSY -> ARMED: when the pipeline is empty and acc_valid=0.
  - para_clear in any state: bitmap and err cleared, go to EMPTY. In-flight beats still complete using already-captured parameters.
  - para_wr_en in ARMED/BUSY: ignored, err_sticky=1.
  - para_wr_addr >= CHANNEL_OUT_NUM: ignored, err_sticky=1.
  - para_wr_en and para_clear in the same cycle: clear wins, write dropped.
- Data path: a beat is accepted when acc_valid=1 and para_ready=1. acc_valid while para_ready=0 drops the beat and sets err_sticky=1. No backpressure; one beat per cycle sustained.
- Pipeline: fixed latency 5; a beat accepted at cycle t appears with shift_valid=1 at t+5. Channel parameters are captured into stage 1 alongside the data.
  - S1: s = sat_ACC(acc + bias), using an ACC_WIDTH+1 sum saturated to ACC_WIDTH.
  - S2/S3: p = s * scale, signed 64-bit product, two-stage multiply.
  - S4: r = (p + (shift>0 ? 2^(shift-1) : 0)) >>> shift. The sum is 65-bit, the shift arithmetic; this gives round-half-up toward +inf.
  - S5: out = saturate r to [-32768, 32767].
- shift_data_out holds its last value when shift_valid=0.
- Reset mid-operation: all in-flight beats are discarded; shift_valid=0 on the cycle after rst.

Decomposition:
- Shared package / Para.v holds:
  - `PICTURE_NUM, `WIDTH_DATA
  - ACC_WIDTH_DEF=32, OUT_WIDTH=16
  - OUT_MAX=32767, OUT_MIN=-32768
  - a lane-index macro (j*`PICTURE_NUM+i)
- One sub-module, requant_lane: the S1..S5 pipeline for a single lane, instantiated LANES times in a generate loop. The top holds the parameter register file, the bitmap/state machine and the valid shift register.

Test Plan:
- Load all 8 channels (bias=28, scale=1, shift=0); drive acc=100 on every lane -> para_ready=1 one cycle after the last write; every lane outputs 128, shift_valid at t+5.
- Channel 3: bias=0, scale=3, shift=4; acc=1000 -> 188. acc=-3, scale=1, shift=1 -> -1 (round-half-up).
- Saturation:
  - acc=0x7FFFFFF0, bias=0x100, scale=1, shift=0 -> 32767.
  - acc=-100000, bias=0, scale=1, shift=0 -> -32768.
- Back-to-back beats for 20 cycles with distinct per-lane values -> 20 consecutive valid outputs, in order, with correct lane packing (lane k = j*`PICTURE_NUM+i).
- Protocol errors:
  - Load only 7 channels, then acc_valid -> no shift_valid, err_sticky=1.
  - para_wr_en while ARMED -> err_sticky=1, parameter unchanged.
  - para_clear -> err_sticky=0, para_ready=0.
- Reset mid-stream (rst asserted 2 cycles after 3 accepted beats) -> shift_valid=0 from the next cycle; no stale outputs; para_ready=0.
